// File: rtl/gpu_cache_pkg.sv
// gpu_cache_pkg: shared widths, FSM state encodings and beat-address helper for the L1 miss responder
package gpu_cache_pkg;
  localparam int ADDR_W = 13;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 32;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int BIDX_W = $clog2(BEATS);
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_WAIT = 2'd2;
  localparam state_t S_FILL = 2'd3;
  typedef logic [ADDR_W+BIDX_W-1:0] beat_addr_t;
  function automatic beat_addr_t beat_addr(logic [ADDR_W-1:0] line_addr, logic [BIDX_W-1:0] idx);
    return {line_addr, idx};
  endfunction
endpackage

// File: rtl/gpu_req_fifo.sv
// gpu_req_fifo: circular request FIFO; entry-valid/data vectors are exported only when GPU_MISS_MERGE_EN is defined
module gpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef GPU_MISS_MERGE_EN
  ,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][W-1:0]  ent_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign dout  = mem[rd_ptr];
  assign empty = count == '0;
`ifdef GPU_MISS_MERGE_EN
  assign ent_data = mem;
  // An entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) ent_valid[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
  end
`endif
  // Pointer, storage and occupancy update; caller guarantees no push when full or pop when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/gpu_miss_responder.sv
// gpu_miss_responder: queues L1 miss lines, fetches eight beats each from memory, returns assembled fills; GPU_MISS_MERGE_EN merges duplicate requests
module gpu_miss_responder
  import gpu_cache_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output beat_addr_t        mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [BEAT_W-1:0] mem_rsp_data,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              busy
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t state;
  logic [ADDR_W-1:0] cur_addr, head;
  logic [BIDX_W-1:0] beat_idx;
  logic [LINE_W-1:0] line;
  logic [CW-1:0] count, cnt_nxt;
  logic ready_q, empty, push, pop, match, last;
`ifdef GPU_MISS_MERGE_EN
  logic [QDEPTH-1:0] ent_valid;
  logic [QDEPTH-1:0][ADDR_W-1:0] ent_data;
  // A request matching a queued or in-flight line is absorbed by that line's fill
  always_comb begin
    match = state != S_IDLE && cur_addr == req_addr;
    for (int i = 0; i < QDEPTH; i++) match = match | (ent_valid[i] && ent_data[i] == req_addr);
  end
  assign req_ready = ready_q || match;
`else
  assign match = 1'b0;
  assign req_ready = ready_q;
`endif
  assign push = req_valid && req_ready && !match;
  assign pop = state == S_IDLE && !empty;
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  assign last = beat_idx == BIDX_W'(BEATS - 1);
  assign mem_rd_valid = state == S_REQ;
  assign mem_rd_addr = beat_addr(cur_addr, beat_idx);
  assign fill_valid = state == S_FILL;
  assign fill_addr = cur_addr;
  assign fill_data = line;
  assign busy = !empty || state != S_IDLE;
  gpu_req_fifo #(.DEPTH(QDEPTH), .W(ADDR_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(req_addr),
    .dout(head),
    .empty(empty),
    .count(count)
`ifdef GPU_MISS_MERGE_EN
    ,
    .ent_valid(ent_valid),
    .ent_data(ent_data)
`endif
  );
  // Line FSM: pop head, request one beat at a time, land it in WAIT, hold the fill until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cur_addr <= '0;
      beat_idx <= '0;
      line <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= cnt_nxt != CW'(QDEPTH);
      if (pop) begin
        cur_addr <= head;
        beat_idx <= '0;
        state <= S_REQ;
      end
      if (state == S_REQ && mem_rd_ready) state <= S_WAIT;
      if (state == S_WAIT && mem_rsp_valid) begin
        line[beat_idx*BEAT_W +: BEAT_W] <= mem_rsp_data;
        beat_idx <= last ? beat_idx : beat_idx + 1'b1;
        state <= last ? S_FILL : S_REQ;
      end
      if (state == S_FILL && fill_ready) state <= S_IDLE;
    end
  end
endmodule

// File: doc/gpu_miss_responder.md
Name: gpu_miss_responder

Overview:
- Services line-fill requests issued by the L1 cache's pending-request table on a miss.
- Queues miss addresses and fetches each 256-bit line from memory as eight 32-bit beats.
- Assembles each line and returns it to L1 as one fill transaction tagged with the line address.
- Sits between the L1 cache and the memory read port; it is the responder side of the L1 miss interface.

Parameters:
- ADDR_W, 13, line address (tag) width; matches the L1 request width.
- LINE_W, 256, cache line width in bits.
- BEAT_W, 32, memory data beat width; BEATS = LINE_W/BEAT_W = 8.
- QDEPTH, 4, request FIFO depth (power of two, at least 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  L1 miss request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  missed line address.
- mem_rd_valid  out  1  memory beat read request valid.
- mem_rd_ready  in  1  memory accepts the beat read.
- mem_rd_addr  out  ADDR_W+3  beat address = {line_addr, beat_idx[2:0]}.
- mem_rsp_valid  in  1  read data beat valid (single-cycle pulse).
- mem_rsp_data  in  BEAT_W  read data beat.
- fill_valid  out  1  assembled line ready for L1.
- fill_ready  in  1  L1 accepts the fill.
- fill_addr  out  ADDR_W  line address of the fill.
- fill_data  out  LINE_W  assembled line.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async assert, sync deassert usage):
  - All outputs 0; FIFO emptied; FSM to IDLE; beat_idx = 0; line buffer cleared.
  - Reset mid-operation discards in-flight lines. Memory responses arriving after reset are ignored unless the FSM is in WAIT.
- Request side:
  - A request is accepted when req_valid && req_ready.
  - req_ready = !fifo_full, registered from the FIFO count. It does not depend on same-cycle pops.
  - When the FIFO is full, a simultaneous pop does not raise req_ready until the next cycle.
- FSM states: IDLE, REQ, WAIT, FILL.
  - IDLE: if the FIFO is non-empty, pop the head into cur_addr, set beat_idx = 0, go to REQ. The pop and entry into REQ happen in the same edge, so there is 1 cycle from FIFO head to mem_rd_valid.
  - REQ: mem_rd_valid = 1 and mem_rd_addr = {cur_addr, beat_idx}. On mem_rd_ready, go to WAIT. Address and valid hold stable until ready.
  - WAIT: on mem_rsp_valid, write mem_rsp_data into line[beat_idx*32 +: 32] (beat 0 goes to bits [31:0]).
    - If beat_idx == 7, go to FILL.
    - Otherwise increment beat_idx and go to REQ.
  - FILL: fill_valid = 1, fill_addr = cur_addr, fill_data = line, all held stable until fill_ready. On handshake, go to IDLE. Back-to-back: IDLE pops next cycle.
- Only one beat is outstanding at a time. mem_rsp_valid outside WAIT is ignored.
- Minimum latency per line, with zero memory wait: 1 (IDLE) + 8×(REQ+WAIT) + 1 (FILL) = 18 cycles from accept to fill_valid when the FIFO is empty.
- Requests are serviced in strict FIFO order. Duplicate addresses are serviced separately (see the optional feature).
- beat_idx is 3 bits and wraps 7→0 only via IDLE re-init.

Optional Feature:
- Macro: GPU_MISS_MERGE_EN.
- Defined:
  - An accepted req_addr equal to any valid FIFO entry, or to cur_addr while the FSM is not IDLE, is accepted (req_ready honoured) but not enqueued.
  - The matching fill serves it.
  - A merge is allowed even when req_ready would be low due to full; req_ready = !full || match.
- Undefined: no comparison; every accepted request is enqueued and yields its own fill.

Decomposition:
- Package gpu_cache_pkg:
  - ADDR_W, LINE_W, BEAT_W, BEATS localparams.
  - State enum (IDLE, REQ, WAIT, FILL).
  - Beat-address type.
- Sub-module gpu_req_fifo:
  - Parameterised depth/width circular FIFO.
  - Push/pop/full/empty/count.
  - Exposes entry-valid and data vectors for merge compare under GPU_MISS_MERGE_EN.

Test Plan:
- Single miss:
  - Stimulus: req_addr=13'h0A5; memory returns beat k = 32'hA5A5_0000+k with 0-cycle ready.
  - Response: fill_addr=13'h0A5; fill_data[31:0]=32'hA5A50000 and [255:224]=32'hA5A50007; fill_valid 18 cycles after accept.
- Backpressure:
  - Stimulus: hold mem_rd_ready low 3 cycles on beat 2; hold fill_ready low 5 cycles.
  - Response: mem_rd_addr={13'h0A5,3'd2} stable throughout; fill_valid and fill_data stable until handshake.
- FIFO full:
  - Stimulus: push 5 requests 13'h001..13'h005 while the memory stalls.
  - Response: req_ready=0 after the 4th (QDEPTH=4 with head not yet popped, or 5 once popped); fills emitted in order 001,002,...; none lost.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT of beat 4, release, issue 13'h1FF.
  - Response: all outputs 0 during reset; no stale fill; next fill for 13'h1FF is complete and correct.
- Spurious response:
  - Stimulus: mem_rsp_valid pulsed in IDLE and REQ with 32'hDEADBEEF.
  - Response: line contents unaffected; subsequent fill matches only the WAIT-cycle data.
- Merge (GPU_MISS_MERGE_EN):
  - Stimulus: requests 13'h010, 13'h010, 13'h020, with 13'h010 also sent while in flight.
  - Response: exactly two fills (010, 020).
  - Without the macro: four fills in request order.
